// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch direction predictor for the RV32I core.
// Ports: clk, rst (sync, active-high); fetch_valid/fetch_pc -> pred_valid/pred_taken (1-cycle latency);
// upd_valid/upd_pc/upd_taken/upd_pred_taken train the table and drive mispredict;
// init_done marks the end of the table sweep; stat_branches/stat_mispred are event counters.
// Optional macro BP_STATS_EN enables the stat counters; otherwise both stat outputs are tied to 0.
module branch_predictor #(
  parameter int          IDX_BITS   = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred_taken,
  output logic        mispredict,
  output logic        init_done,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);
  typedef enum logic {INIT, RUN} state_t;
  state_t              state;
  logic [IDX_BITS-1:0] init_idx;
  logic [1:0]          tbl [2**IDX_BITS];
  logic [IDX_BITS-1:0] fetch_idx, upd_idx;
  logic [1:0]          upd_cur, upd_next;
  logic                mis;
  logic                unused_pc_bits;
  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_cur   = tbl[upd_idx];
  assign upd_next  = upd_taken ? ((upd_cur == 2'b11) ? upd_cur : upd_cur + 2'b01)
                               : ((upd_cur == 2'b00) ? upd_cur : upd_cur - 2'b01);
  assign mis       = upd_valid & (upd_taken ^ upd_pred_taken);
  // Upper and byte-offset PC bits deliberately alias onto the same entry.
  assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0], upd_pc[31:IDX_BITS+2], upd_pc[1:0]};
  // The single table write port belongs to the sweep in INIT and to training in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_idx   <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      pred_valid <= fetch_valid;
      pred_taken <= (state == RUN) & tbl[fetch_idx][1];
      mispredict <= mis;
      if (state == INIT) begin
        tbl[init_idx] <= INIT_STATE;
        init_idx      <= init_idx + 1'b1;
        if (&init_idx) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end else if (upd_valid) begin
        tbl[upd_idx] <= upd_next;
      end
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] cnt_br, cnt_mp;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_br <= '0;
      cnt_mp <= '0;
    end else if (state == RUN && upd_valid) begin
      cnt_br <= cnt_br + 32'd1;
      if (mis) cnt_mp <= cnt_mp + 32'd1;
    end
  end
  assign stat_branches = cnt_br;
  assign stat_mispred  = cnt_mp;
`else
  assign stat_branches = 32'h0;
  assign stat_mispred  = 32'h0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst, fetch_valid, upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] fetch_pc, upd_pc;
  logic        pred_valid, pred_taken, mispredict, init_done;
  logic [31:0] stat_branches, stat_mispred;
  int          errors = 0;
  int          checks = 0;
  branch_predictor dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .mispredict(mispredict), .init_done(init_done),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pred_valid"}, pred_valid, 0);
    chk({tag, "_pred_taken"}, pred_taken, 0);
    chk({tag, "_mispredict"}, mispredict, 0);
    chk({tag, "_init_done"}, init_done, 0);
  endtask
  initial begin
    rst = 1; fetch_valid = 1; fetch_pc = 32'h100;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_pred_taken = 0;
    tick;
    chk_reset("reset");
    chk("reset_stat_br", stat_branches, 0);
    chk("reset_stat_mp", stat_mispred, 0);
    rst = 0;
    for (int i = 1; i < 64; i++) begin
      tick;
      chk("sweep_init_done", init_done, 0);
      chk("sweep_pred", pred_taken, 0);
    end
    tick;
    chk("edge64_init_done", init_done, 1);
    chk("edge64_pred", pred_taken, 0);
    chk("edge64_pred_valid", pred_valid, 1);
    tick;
    chk("run_pred_0x100", pred_taken, 0);
    fetch_valid = 0; upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_pred_taken = 0;
    tick;
    chk("train1_mis", mispredict, 1);
    chk("train1_pred_valid", pred_valid, 0);
    tick;
    chk("train2_mis", mispredict, 1);
    upd_valid = 0; fetch_valid = 1; fetch_pc = 32'h200;
    tick;
    chk("trained_pred", pred_taken, 1);
    chk("idle_mis", mispredict, 0);
    fetch_valid = 0; upd_valid = 1; upd_pred_taken = 1;
    tick;
    chk("train3_mis", mispredict, 0);
    upd_taken = 0;
    tick;
    chk("down1_mis", mispredict, 1);
    upd_valid = 0; fetch_valid = 1;
    tick;
    chk("down1_pred_10", pred_taken, 1);
    fetch_valid = 0; upd_valid = 1;
    tick;
    upd_valid = 0; fetch_valid = 1;
    tick;
    chk("down2_pred_01", pred_taken, 0);
    fetch_valid = 0; upd_valid = 1;
    tick;
    tick;
    upd_taken = 1; upd_pred_taken = 0;
    tick;
    upd_valid = 0; fetch_valid = 1;
    tick;
    chk("hyst_pred", pred_taken, 0);
    fetch_pc = 32'h300; upd_valid = 1; upd_pc = 32'h300; upd_taken = 1; upd_pred_taken = 0;
    tick;
    chk("same_cycle_pred", pred_taken, 0);
    chk("same_cycle_mis", mispredict, 1);
    upd_valid = 0;
    tick;
    chk("refetch_pred", pred_taken, 1);
    fetch_pc = 32'h400;
    tick;
    chk("alias_pred", pred_taken, 1);
    fetch_pc = 32'h204;
    tick;
    chk("other_idx_pred", pred_taken, 0);
    upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_pred_taken = 1;
    tick;
    upd_valid = 0; fetch_pc = 32'h200;
    tick;
    chk("pre_rst_pred", pred_taken, 1);
    rst = 1; upd_valid = 1; upd_pred_taken = 0;
    tick;
    chk_reset("rst_run");
    rst = 0; upd_valid = 0;
    for (int i = 0; i < 20; i++) tick;
    chk("idx20_init_done", init_done, 0);
    rst = 1;
    tick;
    chk_reset("rst_init");
    rst = 0; upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_pred_taken = 0;
    for (int i = 1; i < 64; i++) begin
      tick;
      chk("resweep_init_done", init_done, 0);
      chk("resweep_mis", mispredict, 1);
      chk("resweep_pred", pred_taken, 0);
    end
    upd_valid = 0;
    tick;
    chk("resweep_done", init_done, 1);
    chk("resweep_mis_idle", mispredict, 0);
    tick;
    chk("post_rst_pred_0x200", pred_taken, 0);
    chk("stat_br_after_init", stat_branches, 0);
    fetch_valid = 0; upd_valid = 1; upd_pc = 32'h208;
    for (int i = 0; i < 10; i++) begin
      upd_taken = i[0];
      upd_pred_taken = (i < 3) ? ~i[0] : i[0];
      tick;
    end
    upd_valid = 0;
    tick;
`ifdef BP_STATS_EN
    chk("stat_branches_10", stat_branches, 10);
    chk("stat_mispred_3", stat_mispred, 3);
    force dut.cnt_br = 32'hFFFFFFFF;
    #1;
    release dut.cnt_br;
    upd_valid = 1; upd_taken = 1; upd_pred_taken = 1;
    tick;
    upd_valid = 0;
    chk("stat_branches_wrap", stat_branches, 0);
    chk("stat_mispred_hold", stat_mispred, 3);
`else
    chk("stat_branches_tied", stat_branches, 0);
    chk("stat_mispred_tied", stat_mispred, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
